// File: rtl/uart_frame_loader_pkg.sv
// Shared definitions for the framed byte-stream loaders: FSM state encoding,
// default framing bytes and the inter-byte timeout conversion.
package gusn_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        START,
        WAIT,
        SEND,
        ABORT
    } state_t;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] DEF_NACK_BYTE = 8'h3F;

    // Clock cycles in a timeout window of timeout_us microseconds; 0 means no timeout.
    function automatic int unsigned timeout_cycles(input longint unsigned clk_freq,
                                                   input longint unsigned timeout_us);
        longint unsigned cyc;
        cyc = (clk_freq * timeout_us) / 64'd1_000_000;
        return 32'(cyc);
    endfunction

endpackage

// File: rtl/uart_frame_loader_frame_gap_timer.sv
// frame_gap_timer: down-counter watchdog for gaps in a byte stream.
// load re-arms the counter to CYCLES; while enable is high it counts down and
// flags expired once it sits at zero. CYCLES = 0 never expires.
module frame_gap_timer #(
    parameter int unsigned CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int W = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

    logic [W-1:0] cnt;

    // Reload on every byte, otherwise count down to zero and hold there.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(CYCLES);
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (CYCLES != 0) && enable && (cnt == '0);

endmodule

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: hunts for a sync byte, streams NBYTES of payload into the
// network memory port, starts the network and returns its result (or a NACK)
// as one ASCII byte to the UART transmitter.
// Build option: GUSN_FRAME_CSUM_EN adds an XOR trailer byte checked in CHECK.
//
// state | meaning
// IDLE  | waiting for SYNC_BYTE, other bytes dropped
// LOAD  | writing payload bytes, gap timer armed
// CHECK | waiting for the XOR trailer (checksum build only)
// START | one-cycle net_start pulse
// WAIT  | waiting for net_done, latch result
// SEND  | request transmit of the result once tx is free
// ABORT | request transmit of NACK once tx is free
module uart_frame_loader
    import gusn_loader_pkg::*;
#(
    parameter int         NBYTES     = 784,
    parameter int         CLK_FREQ   = 100_000_000,
    parameter int         TIMEOUT_US = 1000,
    parameter logic [7:0] SYNC_BYTE  = DEF_SYNC_BYTE,
    parameter int         IDX_W      = 4,
    parameter logic [7:0] ASCII_BASE = 8'h30,
    parameter logic [7:0] NACK_BYTE  = DEF_NACK_BYTE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             rx_error,
    output logic             mem_rst,
    output logic             mem_we,
    output logic [7:0]       mem_wdata,
    output logic             net_start,
    input  logic             net_done,
    input  logic [IDX_W-1:0] net_result,
    output logic             tx_rq,
    output logic [7:0]       tx_data,
    input  logic             tx_busy,
    output logic             busy,
    output logic [IDX_W-1:0] result_q,
    output logic             frame_err,
    output logic [15:0]      frames_ok
);

    localparam int unsigned GAP_CYCLES = timeout_cycles(64'(CLK_FREQ), 64'(TIMEOUT_US));
    localparam logic [15:0] LAST_IDX   = 16'(NBYTES - 1);

    state_t      state, state_nxt;
    logic [15:0] byte_cnt;
    logic        tmr_load, tmr_en, tmr_expired;
    logic        begin_frame, take_byte, abort_now, take_result, result_sent;
`ifdef GUSN_FRAME_CSUM_EN
    logic [7:0]  csum;
`endif

    frame_gap_timer #(
        .CYCLES (GAP_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake pulses and datapath strobes. A byte arriving in the
    // expiry cycle takes priority over the timeout; rx_error takes priority over both.
    always_comb begin
        state_nxt   = state;
        net_start   = 1'b0;
        tx_rq       = 1'b0;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;
        begin_frame = 1'b0;
        take_byte   = 1'b0;
        abort_now   = 1'b0;
        take_result = 1'b0;
        result_sent = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    begin_frame = 1'b1;
                    tmr_load    = 1'b1;
                    state_nxt   = LOAD;
                end
            end
            LOAD: begin
                tmr_en = 1'b1;
                if (rx_error) begin
                    abort_now = 1'b1;
                    state_nxt = ABORT;
                end else if (rx_valid) begin
                    take_byte = 1'b1;
                    tmr_load  = 1'b1;
                    if (byte_cnt == LAST_IDX) begin
`ifdef GUSN_FRAME_CSUM_EN
                        state_nxt = CHECK;
`else
                        state_nxt = START;
`endif
                    end
                end else if (tmr_expired) begin
                    abort_now = 1'b1;
                    state_nxt = ABORT;
                end
            end
`ifdef GUSN_FRAME_CSUM_EN
            CHECK: begin
                tmr_en = 1'b1;
                if (rx_error) begin
                    abort_now = 1'b1;
                    state_nxt = ABORT;
                end else if (rx_valid) begin
                    if (rx_data == csum) begin
                        state_nxt = START;
                    end else begin
                        abort_now = 1'b1;
                        state_nxt = ABORT;
                    end
                end else if (tmr_expired) begin
                    abort_now = 1'b1;
                    state_nxt = ABORT;
                end
            end
`endif
            START: begin
                net_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (net_done) begin
                    take_result = 1'b1;
                    state_nxt   = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_rq       = 1'b1;
                    result_sent = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            ABORT: begin
                if (!tx_busy) begin
                    tx_rq     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Memory port, byte counter, result/transmit registers and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rst   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            byte_cnt  <= '0;
            tx_data   <= NACK_BYTE;
            result_q  <= '0;
            frame_err <= 1'b0;
            frames_ok <= '0;
        end else begin
            mem_rst <= begin_frame;
            mem_we  <= take_byte;
            if (take_byte) begin
                mem_wdata <= rx_data;
            end
            if (begin_frame) begin
                byte_cnt <= '0;
            end else if (take_byte) begin
                byte_cnt <= byte_cnt + 16'd1;
            end
            if (begin_frame) begin
                frame_err <= 1'b0;
            end else if (abort_now) begin
                frame_err <= 1'b1;
            end
            if (abort_now) begin
                tx_data <= NACK_BYTE;
            end else if (take_result) begin
                tx_data  <= ASCII_BASE + 8'(net_result);
                result_q <= net_result;
            end
            if (result_sent) begin
                frames_ok <= frames_ok + 16'd1;
            end
        end
    end

`ifdef GUSN_FRAME_CSUM_EN
    // Running XOR of the payload, compared against the trailer byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= '0;
        end else if (begin_frame) begin
            csum <= '0;
        end else if (take_byte) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

    assign busy = (state != IDLE);

endmodule
